// File: rtl/decode_cycle_pkg.sv
// Shared definitions for the decode stage: opcodes, instruction field positions,
// the ID/EX record layout and the bubble value loaded on flush/hazard/reset.
package decode_cycle_pkg;

    localparam int DW   = 16;
    localparam int NREG = 16;
    localparam int AW   = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_LUI  = 4'h8;
    localparam logic [3:0] OP_JAL  = 4'h9;
    localparam logic [3:0] NOP_OP  = 4'hF;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int F2_HI = 11;
    localparam int F2_LO = 8;
    localparam int F1_HI = 7;
    localparam int F1_LO = 4;
    localparam int F0_HI = 3;
    localparam int F0_LO = 0;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic alusrc;
        logic branch;
        logic jump;
    } ctrl_t;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [3:0]    op;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        ctrl_t         ctrl;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '{valid: 1'b0, pc: '0, op: NOP_OP, rd: '0,
                                      rs1: '0, rs2: '0, a: '0, b: '0, imm: '0,
                                      ctrl: '0};

    function automatic logic [DW-1:0] sext4(input logic [3:0] f);
        return {{(DW-4){f[3]}}, f};
    endfunction

endpackage

// File: rtl/decode_cycle_if.sv
// Fetch/execute/writeback facing signals of the decode stage, bundled as one interface.
interface decode_cycle_if;
    import decode_cycle_pkg::*;

    logic [DW-1:0] ir;
    logic [DW-1:0] currpc;
    logic          if_valid;
    logic          stall;
    logic          flush;
    logic          ex_memread;
    logic [AW-1:0] ex_rd;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    logic          hazard;
    logic          id_valid;
    logic [DW-1:0] id_pc;
    logic [3:0]    id_op;
    logic [AW-1:0] id_rd;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic [DW-1:0] id_a;
    logic [DW-1:0] id_b;
    logic [DW-1:0] id_imm;
    logic          id_regwrite;
    logic          id_memread;
    logic          id_memwrite;
    logic          id_alusrc;
    logic          id_branch;
    logic          id_jump;

    modport master (
        output ir, currpc, if_valid, stall, flush, ex_memread, ex_rd,
               wb_we, wb_addr, wb_data,
        input  hazard, id_valid, id_pc, id_op, id_rd, id_rs1, id_rs2, id_a, id_b,
               id_imm, id_regwrite, id_memread, id_memwrite, id_alusrc,
               id_branch, id_jump
    );

    modport slave (
        input  ir, currpc, if_valid, stall, flush, ex_memread, ex_rd,
               wb_we, wb_addr, wb_data,
        output hazard, id_valid, id_pc, id_op, id_rd, id_rs1, id_rs2, id_a, id_b,
               id_imm, id_regwrite, id_memread, id_memwrite, id_alusrc,
               id_branch, id_jump
    );

endinterface

// File: rtl/decode_cycle_reg_file.sv
// 2-read 1-write register file with r0 hardwired to zero and write-through
// so a read of the register being written this cycle sees the new value.
module reg_file_component
    import decode_cycle_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata
);

    logic [DW-1:0] regs [NREG];
    logic          wr_en;

    assign wr_en = we && (waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == '0)                     rdata1 = '0;
        else if (wr_en && waddr == raddr1)    rdata1 = wdata;
        rdata2 = regs[raddr2];
        if (raddr2 == '0)                     rdata2 = '0;
        else if (wr_en && waddr == raddr2)    rdata2 = wdata;
    end

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: decodes the fetched word, reads operands, detects load-use hazards
// and registers the result into the ID/EX boundary.
module decode_cycle
    import decode_cycle_pkg::*;
(
    input logic           clk,
    input logic           rst,
    decode_cycle_if.slave bus
);

    idex_t         dec;
    idex_t         load;
    idex_t         idex;
    logic          uses_rs2;
    logic          hazard_raw;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic [3:0]    f2;
    logic [3:0]    f1;
    logic [3:0]    f0;

    assign f2 = bus.ir[F2_HI:F2_LO];
    assign f1 = bus.ir[F1_HI:F1_LO];
    assign f0 = bus.ir[F0_HI:F0_LO];

    // Unused register indices stay 0 so they never match a load destination.
    always_comb begin
        dec      = IDEX_BUBBLE;
        dec.pc   = bus.currpc;
        uses_rs2 = 1'b0;
        case (bus.ir[OP_HI:OP_LO])
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                dec.op = bus.ir[OP_HI:OP_LO];
                dec.rd = f2;
                dec.rs1 = f1;
                dec.rs2 = f0;
                uses_rs2 = 1'b1;
                dec.ctrl.regwrite = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                dec.op = bus.ir[OP_HI:OP_LO];
                dec.rd = f2;
                dec.rs1 = f1;
                dec.imm = sext4(f0);
                dec.ctrl.regwrite = 1'b1;
                dec.ctrl.alusrc = 1'b1;
                dec.ctrl.memread = (bus.ir[OP_HI:OP_LO] == OP_LW);
            end
            OP_SW: begin
                dec.op = OP_SW;
                dec.rs1 = f1;
                dec.rs2 = f2;
                uses_rs2 = 1'b1;
                dec.imm = sext4(f0);
                dec.ctrl.memwrite = 1'b1;
                dec.ctrl.alusrc = 1'b1;
            end
            OP_BEQ: begin
                dec.op = OP_BEQ;
                dec.rs1 = f2;
                dec.rs2 = f1;
                uses_rs2 = 1'b1;
                dec.imm = sext4(f0);
                dec.ctrl.branch = 1'b1;
            end
            OP_LUI: begin
                dec.op = OP_LUI;
                dec.rd = f2;
                dec.imm = {bus.ir[F1_HI:F0_LO], 8'h00};
                dec.ctrl.regwrite = 1'b1;
                dec.ctrl.alusrc = 1'b1;
            end
            OP_JAL: begin
                dec.op = OP_JAL;
                dec.rd = f2;
                dec.imm = sext4(f0);
                dec.ctrl.regwrite = 1'b1;
                dec.ctrl.jump = 1'b1;
            end
            default: begin
                dec.op = NOP_OP;
            end
        endcase
    end

    reg_file_component u_regs (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (dec.rs1),
        .raddr2 (dec.rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (bus.wb_we),
        .waddr  (bus.wb_addr),
        .wdata  (bus.wb_data)
    );

    always_comb begin
        load       = dec;
        load.a     = rdata1;
        load.b     = rdata2;
        load.valid = bus.if_valid;
        if (!bus.if_valid) load.ctrl = '0;
    end

    assign hazard_raw = bus.if_valid && bus.ex_memread && (bus.ex_rd != '0) &&
                        ((bus.ex_rd == dec.rs1) || (uses_rs2 && (bus.ex_rd == dec.rs2)));
    assign bus.hazard = hazard_raw && !rst;

    // Priority: flush, then stall (hold), then hazard bubble, then normal load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             idex <= IDEX_BUBBLE;
        else if (bus.flush)  idex <= IDEX_BUBBLE;
        else if (bus.stall)  idex <= idex;
        else if (hazard_raw) idex <= IDEX_BUBBLE;
        else                 idex <= load;
    end

    assign bus.id_valid    = idex.valid;
    assign bus.id_pc       = idex.pc;
    assign bus.id_op       = idex.op;
    assign bus.id_rd       = idex.rd;
    assign bus.id_rs1      = idex.rs1;
    assign bus.id_rs2      = idex.rs2;
    assign bus.id_a        = idex.a;
    assign bus.id_b        = idex.b;
    assign bus.id_imm      = idex.imm;
    assign bus.id_regwrite = idex.ctrl.regwrite;
    assign bus.id_memread  = idex.ctrl.memread;
    assign bus.id_memwrite = idex.ctrl.memwrite;
    assign bus.id_alusrc   = idex.ctrl.alusrc;
    assign bus.id_branch   = idex.ctrl.branch;
    assign bus.id_jump     = idex.ctrl.jump;

endmodule
